nco_sweep_ctrl: RTL

//  Upstream stage of the NCO: issues a linear frequency sweep as frequency tuning words (FTW).

---
 rtl/nco_sweep_ctrl_if.sv | 11 +
 rtl/nco_sweep_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sweep_ctrl_if.sv
// Tuning-word stream from the sweep controller (master) to the NCO core (slave).
interface nco_sweep_ctrl_if #(
    parameter int FTW_W = 32
);
    logic [FTW_W-1:0] ftw_out;
    logic             ftw_valid;
    logic             ftw_ready;

    modport master (output ftw_out, output ftw_valid, input ftw_ready);
    modport slave  (input ftw_out, input ftw_valid, output ftw_ready);
endinterface

// File: rtl/nco_sweep_ctrl.sv
// Linear FTW sweep generator: steps start_ftw toward stop_ftw, holding each word for a dwell time.
// Build macro NCO_SWEEP_LOOP_EN: repeat the sweep until abort instead of finishing once.
module nco_sweep_ctrl #(
    parameter int FTW_W   = 32,
    parameter int STEP_W  = 16,
    parameter int DWELL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [FTW_W-1:0]   start_ftw,
    input  logic [FTW_W-1:0]   stop_ftw,
    input  logic [STEP_W-1:0]  step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               dir_down,
    nco_sweep_ctrl_if.master   ftw_if,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DWELL  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    localparam logic [DWELL_W-1:0] DWELL_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    state_t             state_r;
    state_t             state_nxt_s;
    logic [FTW_W-1:0]   cur_r;
    logic [FTW_W-1:0]   cur_nxt_s;
    logic               last_r;
    logic               last_nxt_s;
    logic [DWELL_W-1:0] cnt_r;
    logic [DWELL_W-1:0] cnt_nxt_s;
    logic [FTW_W-1:0]   stop_r;
    logic [STEP_W-1:0]  step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               dir_down_r;
`ifdef NCO_SWEEP_LOOP_EN
    logic [FTW_W-1:0]   start_r;
    logic               degen_r;
`endif
    logic               ftw_valid_r;
    logic               busy_r;
    logic               done_r;
    logic               done_nxt_s;
    logic               start_go_s;
    logic               expire_s;
    logic               degen_s;
    logic [DWELL_W-1:0] dwell_ld_s;
    logic [FTW_W:0]     step_ext_s;
    logic [FTW_W:0]     sum_s;
    logic [FTW_W:0]     diff_s;
    logic [FTW_W-1:0]   adv_ftw_s;
    logic               adv_last_s;

    assign start_go_s = (state_r == ST_IDLE) && start && !abort;
    assign expire_s   = (state_r == ST_DWELL) && (cnt_r == DWELL_ONE);
    assign dwell_ld_s = (dwell_r == {DWELL_W{1'b0}}) ? DWELL_ONE : dwell_r;

    // Configs that can only ever produce the first word
    assign degen_s = (start_ftw == stop_ftw) || (step == {STEP_W{1'b0}}) ||
                     (!dir_down && (start_ftw > stop_ftw)) ||
                     (dir_down && (start_ftw < stop_ftw));

    // Next tuning word with carry/borrow-aware clamp to stop_r
    always_comb begin
        step_ext_s = {{(FTW_W+1-STEP_W){1'b0}}, step_r};
        sum_s      = {1'b0, cur_r} + step_ext_s;
        diff_s     = {1'b0, cur_r} - step_ext_s;
        if (dir_down_r) begin
            if (diff_s[FTW_W] || (diff_s[FTW_W-1:0] <= stop_r)) begin
                adv_ftw_s  = stop_r;
                adv_last_s = 1'b1;
            end else begin
                adv_ftw_s  = diff_s[FTW_W-1:0];
                adv_last_s = 1'b0;
            end
        end else begin
            if (sum_s[FTW_W] || (sum_s[FTW_W-1:0] >= stop_r)) begin
                adv_ftw_s  = stop_r;
                adv_last_s = 1'b1;
            end else begin
                adv_ftw_s  = sum_s[FTW_W-1:0];
                adv_last_s = 1'b0;
            end
        end
    end

    // Control state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; abort overrides every other event
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) state_nxt_s = ST_ISSUE;
                    else       state_nxt_s = ST_IDLE;
                end
                ST_ISSUE: begin
                    if (ftw_if.ftw_ready) state_nxt_s = ST_DWELL;
                    else                  state_nxt_s = ST_ISSUE;
                end
                ST_DWELL: begin
                    if (!expire_s) begin
                        state_nxt_s = ST_DWELL;
                    end else begin
`ifdef NCO_SWEEP_LOOP_EN
                        state_nxt_s = ST_ISSUE;
`else
                        state_nxt_s = last_r ? ST_FINISH : ST_ISSUE;
`endif
                    end
                end
                ST_FINISH: state_nxt_s = ST_IDLE;
                default:   state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        cur_nxt_s  = cur_r;
        last_nxt_s = last_r;
        cnt_nxt_s  = cnt_r;
        done_nxt_s = 1'b0;
        if (abort) begin
            cur_nxt_s = cur_r;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cur_nxt_s  = start_ftw;
                        last_nxt_s = degen_s;
                    end else begin
                        cur_nxt_s = cur_r;
                    end
                end
                ST_ISSUE: begin
                    if (ftw_if.ftw_ready) cnt_nxt_s = dwell_ld_s;
                    else                  cnt_nxt_s = cnt_r;
                end
                ST_DWELL: begin
                    if (!expire_s) begin
                        cnt_nxt_s = cnt_r - DWELL_ONE;
                    end else if (last_r) begin
                        done_nxt_s = 1'b1;
`ifdef NCO_SWEEP_LOOP_EN
                        // A degenerate config stays a one-word pass on every repetition
                        cur_nxt_s  = start_r;
                        last_nxt_s = degen_r;
`endif
                    end else begin
                        cur_nxt_s  = adv_ftw_s;
                        last_nxt_s = adv_last_s;
                    end
                end
                ST_FINISH: done_nxt_s = 1'b0;
                default:   done_nxt_s = 1'b0;
            endcase
        end
    end

    // Datapath, latched configuration and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_r       <= {FTW_W{1'b0}};
            last_r      <= 1'b0;
            cnt_r       <= {DWELL_W{1'b0}};
            stop_r      <= {FTW_W{1'b0}};
            step_r      <= {STEP_W{1'b0}};
            dwell_r     <= {DWELL_W{1'b0}};
            dir_down_r  <= 1'b0;
`ifdef NCO_SWEEP_LOOP_EN
            start_r     <= {FTW_W{1'b0}};
            degen_r     <= 1'b0;
`endif
            ftw_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cur_r       <= cur_nxt_s;
            last_r      <= last_nxt_s;
            cnt_r       <= cnt_nxt_s;
            ftw_valid_r <= (state_nxt_s == ST_ISSUE);
            busy_r      <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_DWELL);
            done_r      <= done_nxt_s;
            if (start_go_s) begin
                stop_r     <= stop_ftw;
                step_r     <= step;
                dwell_r    <= dwell;
                dir_down_r <= dir_down;
`ifdef NCO_SWEEP_LOOP_EN
                start_r    <= start_ftw;
                degen_r    <= degen_s;
`endif
            end
        end
    end

    assign ftw_if.ftw_out   = cur_r;
    assign ftw_if.ftw_valid = ftw_valid_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule
